// File: rtl/tt_io_recorder_pkg.sv
// Shared types and default geometry for the TT I/O recorder.
// Holds the capture FSM state encoding used by the recorder and its interface.
package tt_io_recorder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_TS_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/tt_io_recorder_if.sv
// Bus bundle between a recorder and whoever drives probes, triggers and pops.
// The master side drives control and probe; the slave side is the recorder.
interface tt_io_recorder_if
    import tt_io_recorder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  ena;
    logic                  arm;
    logic [WIDTH-1:0]      probe_in;
    logic [WIDTH-1:0]      trig_mask;
    logic [WIDTH-1:0]      trig_value;
    logic                  rd_en;
    logic [WIDTH+TS_W-1:0] rd_data;
    logic                  rd_valid;
    logic [1:0]            state;
    logic [CW-1:0]         count;

    modport master (
        output ena, arm, probe_in, trig_mask, trig_value, rd_en,
        input  rd_data, rd_valid, state, count
    );

    modport slave (
        input  ena, arm, probe_in, trig_mask, trig_value, rd_en,
        output rd_data, rd_valid, state, count
    );

endinterface

// File: rtl/tt_io_recorder_mem.sv
// Capture storage: DEPTH x DW array, synchronous write, registered read port.
// The array itself is never reset; only the read register clears on rst.
module tt_io_recorder_mem #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register holds its last value between pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DW{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/tt_io_recorder.sv
// Triggered change recorder for a probed bus with delta timestamps and a pop port.
// Define TT_IO_RECORDER_TIMESTAMP_EN to store per-entry delta timestamps.
module tt_io_recorder
    import tt_io_recorder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W
) (
    input  logic            clk,
    input  logic            rst,
    tt_io_recorder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef TT_IO_RECORDER_TIMESTAMP_EN
    localparam int MW = WIDTH + TS_W;
`else
    localparam int MW = WIDTH;
`endif

    state_t           state_r;
    state_t           state_next_s;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] last_r;
    logic             rd_valid_r;
    logic             trig_hit_s;
    logic             changed_s;
    logic             wr_s;
    logic             pop_s;
    logic [MW-1:0]    mem_wdata_s;
    logic [MW-1:0]    mem_rdata_s;

    assign trig_hit_s = ((bus.probe_in & bus.trig_mask) == (bus.trig_value & bus.trig_mask));
    assign changed_s  = (bus.probe_in != last_r);

    // arm takes priority over everything, including a pending pop
    assign wr_s  = !bus.arm && (((state_r == ARMED) && trig_hit_s) ||
                                ((state_r == CAPTURE) && changed_s));
    assign pop_s = !bus.arm && bus.rd_en && (count_r != {CW{1'b0}}) &&
                   ((state_r == CAPTURE) || (state_r == DONE));

    // Occupancy after this cycle's write/pop
    always_comb begin
        count_next_s = count_r;
        if (wr_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_s && !wr_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        if (bus.arm) begin
            state_next_s = ARMED;
        end else begin
            case (state_r)
                IDLE:    state_next_s = IDLE;
                ARMED:   state_next_s = trig_hit_s ? CAPTURE : ARMED;
                CAPTURE: state_next_s = (count_next_s == CW'(DEPTH)) ? DONE : CAPTURE;
                DONE:    state_next_s = (count_next_s == {CW{1'b0}}) ? IDLE : DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else if (bus.ena) begin
            state_r <= state_next_s;
        end
    end

    // Pointers, occupancy, last sample and read-valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            last_r     <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (bus.ena) begin
            if (bus.arm) begin
                wr_ptr_r   <= {AW{1'b0}};
                rd_ptr_r   <= {AW{1'b0}};
                count_r    <= {CW{1'b0}};
                rd_valid_r <= 1'b0;
            end else begin
                if (wr_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                    last_r   <= bus.probe_in;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                count_r    <= count_next_s;
                rd_valid_r <= pop_s;
            end
        end
    end

`ifdef TT_IO_RECORDER_TIMESTAMP_EN
    logic [TS_W-1:0] delta_r;
    logic [TS_W-1:0] delta_inc_s;
    logic [TS_W-1:0] ts_s;

    // The stored stamp counts the write cycle itself, so it is the saturated increment
    assign delta_inc_s = (delta_r == {TS_W{1'b1}}) ? delta_r : (delta_r + TS_W'(1));
    assign ts_s        = (state_r == ARMED) ? {TS_W{1'b0}} : delta_inc_s;

    // Cycles elapsed since the previous write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta_r <= {TS_W{1'b0}};
        end else if (bus.ena) begin
            if (bus.arm || wr_s) begin
                delta_r <= {TS_W{1'b0}};
            end else if (state_r == CAPTURE) begin
                delta_r <= delta_inc_s;
            end
        end
    end

    assign mem_wdata_s = {ts_s, bus.probe_in};
    assign bus.rd_data = mem_rdata_s;
`else
    assign mem_wdata_s = bus.probe_in;
    assign bus.rd_data = {{TS_W{1'b0}}, mem_rdata_s};
`endif

    tt_io_recorder_mem #(
        .DW    (MW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.ena & wr_s),
        .waddr (wr_ptr_r),
        .wdata (mem_wdata_s),
        .re    (bus.ena & pop_s),
        .raddr (rd_ptr_r),
        .rdata (mem_rdata_s)
    );

    assign bus.rd_valid = rd_valid_r;
    assign bus.state    = state_r;
    assign bus.count    = count_r;

endmodule

// File: tb/tb_tt_io_recorder.sv
// Directed self-checking bench for tt_io_recorder (default geometry 8/16/8).
// Expected timestamps follow TT_IO_RECORDER_TIMESTAMP_EN.
module tb_tt_io_recorder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int TS_W  = 8;
`ifdef TT_IO_RECORDER_TIMESTAMP_EN
    localparam int TS_ON = 1;
`else
    localparam int TS_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tt_io_recorder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

    tt_io_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ena = 1'b1; bus.arm = 1'b0; bus.rd_en = 1'b0;
        bus.probe_in = 8'h00; bus.trig_mask = 8'h00; bus.trig_value = 8'h00;
        tick(); tick();
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", bus.rd_data); end
        rst = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_pop got %b exp 0", bus.rd_valid); end
    endtask

    task automatic test_trigger();
        bus.trig_mask = 8'hFF; bus.trig_value = 8'hA5; bus.probe_in = 8'h00;
        pulse_arm();
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL armed_state got %0d exp 1", bus.state); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL no_trig_state got %0d exp 1", bus.state); end
        bus.probe_in = 8'hA5;
        tick();
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL trig_state got %0d exp 2", bus.state); end
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL trig_count got %0d exp 1", bus.count); end
    endtask

    task automatic test_timestamps();
        logic [15:0] exp1;
        logic [15:0] exp2;
        exp1 = {((TS_ON != 0) ? 8'd5 : 8'd0), 8'h01};
        exp2 = {((TS_ON != 0) ? 8'd255 : 8'd0), 8'h02};
        for (int i = 0; i < 4; i++) tick();
        bus.probe_in = 8'h01;
        tick();
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL ts_count1 got %0d exp 2", bus.count); end
        for (int i = 0; i < 299; i++) tick();
        bus.probe_in = 8'h02;
        tick();
        checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL ts_count2 got %0d exp 3", bus.count); end
        bus.rd_en = 1'b1;
        tick();
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h00A5) begin errors++; $display("FAIL entry0 got v=%b %h exp v=1 00a5", bus.rd_valid, bus.rd_data); end
        tick();
        checks++; if (bus.rd_data !== exp1) begin errors++; $display("FAIL entry1 got %h exp %h", bus.rd_data, exp1); end
        tick();
        checks++; if (bus.rd_data !== exp2) begin errors++; $display("FAIL entry2 got %h exp %h", bus.rd_data, exp2); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL drained_count got %0d exp 0", bus.count); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_pop got %b exp 0", bus.rd_valid); end
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL capture_empty_state got %0d exp 2", bus.state); end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_enable_and_overlap();
        bus.ena = 1'b0;
        bus.probe_in = 8'h33;
        tick(); tick();
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL frozen_count got %0d exp 0", bus.count); end
        bus.ena = 1'b1;
        bus.probe_in = 8'h10;
        tick();
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_write_count got %0d exp 1", bus.count); end
        bus.probe_in = 8'h11;
        bus.rd_en = 1'b1;
        tick();
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL overlap_count got %0d exp 1", bus.count); end
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data[7:0] !== 8'h10) begin errors++; $display("FAIL overlap_data got v=%b %h exp v=1 10", bus.rd_valid, bus.rd_data[7:0]); end
        tick();
        checks++; if (bus.rd_data[7:0] !== 8'h11 || bus.count !== 5'd0) begin errors++; $display("FAIL overlap_tail got %h cnt %0d exp 11 cnt 0", bus.rd_data[7:0], bus.count); end
        bus.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_fill_and_drain();
        logic [15:0] exp;
        bus.trig_mask = 8'h00; bus.probe_in = 8'h00;
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            bus.probe_in = 8'(i + 1);
            tick();
        end
        checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL fill_state got %0d exp 3", bus.state); end
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", bus.count); end
        bus.rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = {(((TS_ON != 0) && (k > 0)) ? 8'd1 : 8'd0), 8'(k + 1)};
            tick();
            checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", k, bus.rd_valid); end
            checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", k, bus.rd_data, exp); end
        end
        checks++; if (bus.state !== 2'd0 || bus.count !== 5'd0) begin errors++; $display("FAIL drain_end got st %0d cnt %0d exp st 0 cnt 0", bus.state, bus.count); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL pop17 got %b exp 0", bus.rd_valid); end
        bus.rd_en = 1'b0;
    endtask

    task automatic test_rst_mid_capture();
        bus.trig_mask = 8'h00;
        pulse_arm();
        for (int i = 0; i < 7; i++) begin
            bus.probe_in = 8'(8'h40 + i);
            tick();
        end
        checks++; if (bus.count !== 5'd7 || bus.state !== 2'd2) begin errors++; $display("FAIL pre_rst got cnt %0d st %0d exp cnt 7 st 2", bus.count, bus.state); end
        bus.probe_in = 8'h50;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data[7:0] !== 8'h40) begin errors++; $display("FAIL pre_rst_pop got v=%b %h exp v=1 40", bus.rd_valid, bus.rd_data[7:0]); end
        rst = 1'b1;
        #1;
        checks++; if (bus.state !== 2'd0 || bus.count !== 5'd0) begin errors++; $display("FAIL async_rst got st %0d cnt %0d exp 0 0", bus.state, bus.count); end
        checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin errors++; $display("FAIL async_rst_rd got v=%b %h exp v=0 0000", bus.rd_valid, bus.rd_data); end
        rst = 1'b0;
        bus.trig_mask = 8'hFF; bus.trig_value = 8'h55; bus.probe_in = 8'h55;
        pulse_arm();
        tick();
        checks++; if (bus.count !== 5'd1 || bus.state !== 2'd2) begin errors++; $display("FAIL rearm_trig got cnt %0d st %0d exp cnt 1 st 2", bus.count, bus.state); end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_data !== 16'h0055) begin errors++; $display("FAIL clean_entry0 got %h exp 0055", bus.rd_data); end
        bus.probe_in = 8'h56;
        tick();
        bus.arm = 1'b1; bus.rd_en = 1'b1;
        tick();
        bus.arm = 1'b0; bus.rd_en = 1'b0;
        checks++; if (bus.state !== 2'd1 || bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL arm_with_pop got st %0d cnt %0d v=%b exp st 1 cnt 0 v=0", bus.state, bus.count, bus.rd_valid); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_timestamps();
        test_enable_and_overlap();
        test_fill_and_drain();
        test_rst_mid_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_io_recorder.md
TT_IO_RECORDER -- requirements
Module: tt_io_recorder

Interface
REQ-001 Parameter WIDTH, default 8: width of the probed bus.
REQ-002 Parameter DEPTH, default 16: capture entries; power of two, 4..64.
REQ-003 Parameter TS_W, default 8: delta-timestamp width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ena  in  1  enable; low freezes all state, registered outputs hold.
REQ-007 arm  in  1  one-cycle pulse, clears buffer and enters ARMED.
REQ-008 probe_in  in  WIDTH  sampled bus, such as uo_out or uio_out.
REQ-009 trig_mask  in  WIDTH  bits compared for the trigger.
REQ-010 trig_value  in  WIDTH  trigger pattern.
REQ-011 rd_en  in  1  pop one entry.
REQ-012 rd_data  out  WIDTH+TS_W  registered entry, {timestamp, sample}.
REQ-013 rd_valid  out  1  rd_data holds a popped entry this cycle.
REQ-014 state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-015 count  out  $clog2(DEPTH)+1  entries currently stored.

Function
REQ-016 IDLE, arm: clear count, clear rd/wr pointers, go to ARMED.
REQ-017 ARMED: transition when (probe_in & trig_mask) == (trig_value & trig_mask).
- That cycle, write entry 0 = {0, probe_in} and go to CAPTURE.
- trig_mask all-zero triggers on the first ARMED cycle.
REQ-018 CAPTURE: write an entry only when probe_in differs from the last written sample.
REQ-019 Delta counter: cleared on each write, increments each CAPTURE cycle, saturates at 2^TS_W-1.
- Stored timestamp equals the cycles since the previous write, saturated.
REQ-020 When count reaches DEPTH, the write that fills the buffer moves state to DONE; no further writes.
REQ-021 Pops are legal in CAPTURE and DONE.
- rd_en with count>0: rd_data and rd_valid=1 appear the next cycle; count decrements.
- rd_en with count==0: ignored, rd_valid=0.
REQ-022 Simultaneous write and pop in CAPTURE: count unchanged, both pointers advance.
REQ-023 DONE, last entry popped (count to 0): state returns to IDLE the cycle after the pop.
REQ-024 arm in ARMED, CAPTURE or DONE restarts as in REQ-016; any pending rd_en that cycle is ignored.
REQ-025 Pointers wrap modulo DEPTH.
REQ-026 rd_valid deasserts the cycle after any non-popping cycle.

Reset
REQ-027 On rst: state=IDLE, count=0, pointers=0, delta counter=0, rd_data=0, rd_valid=0, last-sample register=0.
- Storage contents are not reset.
REQ-028 rst asserted mid-capture aborts immediately; post-reset behaviour is identical to power-up.

Configuration
REQ-029 Macro TT_IO_RECORDER_TIMESTAMP_EN.
- Defined: timestamps are stored per REQ-019.
- Undefined: delta counter and timestamp storage are removed; rd_data[WIDTH+TS_W-1:WIDTH] reads 0; port widths are unchanged.

Structure
REQ-030 Shared package tt_io_recorder_pkg holds the state enum (IDLE/ARMED/CAPTURE/DONE) and the default WIDTH/DEPTH/TS_W constants.
REQ-031 Storage is one sub-module, tt_io_recorder_mem: DEPTH x (WIDTH+TS_W), synchronous write, registered read.

Verification
REQ-032 rst, arm, mask=0xFF, value=0xA5; probe 0x00 for 3 cycles, then 0xA5 -> state=CAPTURE, entry0={0,0xA5}.
REQ-033 After trigger, probe changes to 0x01 five cycles later and to 0x02 300 cycles after that (TS_W=8) -> entries {5,0x01} and {255,0x02}.
REQ-034 Probe toggles every cycle for 16+ changes (DEPTH=16) -> state=DONE at count=16; further changes not stored.
REQ-035 DONE, pop 16 times consecutively -> rd_valid for 16 cycles with entries in write order; state=IDLE after the last; 17th rd_en gives rd_valid=0.
REQ-036 rst pulsed mid-CAPTURE with count=7 -> all outputs at reset values within the same cycle; next arm starts clean.
REQ-037 Build without TT_IO_RECORDER_TIMESTAMP_EN, rerun REQ-033 -> entries {0,0x01} and {0,0x02}.
